// File: rtl/axis_frame_len_stats.sv
// Frame length statistics accumulator.
// Live counters track every frame_len_valid pulse; a snapshot copies the live
// set (including a frame arriving in the same cycle) into stable shadow
// outputs, optionally clearing the live set on the same edge.
module axis_frame_len_stats #(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int BYTE_WIDTH  = 48,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic                   frame_len_valid,
  input  logic                   snapshot,
  input  logic                   clear_on_snap,
  output logic [COUNT_WIDTH-1:0] stat_frames,
  output logic [BYTE_WIDTH-1:0]  stat_bytes,
  output logic [LEN_WIDTH-1:0]   stat_min_len,
  output logic [LEN_WIDTH-1:0]   stat_max_len,
  output logic [COUNT_WIDTH-1:0] stat_runt,
  output logic [COUNT_WIDTH-1:0] stat_oversize,
  output logic                   stat_valid
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [BYTE_WIDTH-1:0]  BYT_MAX = {BYTE_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0]   LEN_MAX = {LEN_WIDTH{1'b1}};

  // live set
  logic [COUNT_WIDTH-1:0] frames_q, frames_d, runt_q, runt_d, over_q, over_d;
  logic [BYTE_WIDTH-1:0]  bytes_q, bytes_d;
  logic [LEN_WIDTH-1:0]   min_q, min_d, max_q, max_d;

  // live set with the current cycle's frame folded in (what a snapshot sees)
  logic [COUNT_WIDTH-1:0] upd_frames, upd_runt, upd_over;
  logic [BYTE_WIDTH-1:0]  upd_bytes;
  logic [LEN_WIDTH-1:0]   upd_min, upd_max;
  logic [BYTE_WIDTH:0]    bsum;

  // shadow set
  logic [COUNT_WIDTH-1:0] sh_frames_q, sh_runt_q, sh_over_q;
  logic [BYTE_WIDTH-1:0]  sh_bytes_q;
  logic [LEN_WIDTH-1:0]   sh_min_q, sh_max_q;
  logic                   sh_valid_q;

  // Fold the incoming frame into the live values with saturating arithmetic.
  always_comb begin
    upd_frames = frames_q;
    upd_runt   = runt_q;
    upd_over   = over_q;
    upd_bytes  = bytes_q;
    upd_min    = min_q;
    upd_max    = max_q;
    bsum       = {1'b0, bytes_q} + (BYTE_WIDTH+1)'(frame_len);
    if (frame_len_valid) begin
      if (frames_q != CNT_MAX) upd_frames = frames_q + COUNT_WIDTH'(1);
      upd_bytes = bsum[BYTE_WIDTH] ? BYT_MAX : bsum[BYTE_WIDTH-1:0];
      if (frame_len < min_q) upd_min = frame_len;
      if (frame_len > max_q) upd_max = frame_len;
      if ((frame_len < LEN_WIDTH'(MIN_LEN)) && (runt_q != CNT_MAX))
        upd_runt = runt_q + COUNT_WIDTH'(1);
      if ((frame_len > LEN_WIDTH'(MAX_LEN)) && (over_q != CNT_MAX))
        upd_over = over_q + COUNT_WIDTH'(1);
    end
  end

  // Next live state: cleared when a clearing snapshot is taken, else updated.
  always_comb begin
    frames_d = upd_frames;
    runt_d   = upd_runt;
    over_d   = upd_over;
    bytes_d  = upd_bytes;
    min_d    = upd_min;
    max_d    = upd_max;
    if (snapshot && clear_on_snap) begin
      frames_d = '0;
      runt_d   = '0;
      over_d   = '0;
      bytes_d  = '0;
      min_d    = LEN_MAX;
      max_d    = '0;
    end
  end

  // Live register set; min resets to all-ones as the empty marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      runt_q   <= '0;
      over_q   <= '0;
      bytes_q  <= '0;
      min_q    <= LEN_MAX;
      max_q    <= '0;
    end else begin
      frames_q <= frames_d;
      runt_q   <= runt_d;
      over_q   <= over_d;
      bytes_q  <= bytes_d;
      min_q    <= min_d;
      max_q    <= max_d;
    end
  end

  // Shadow capture; an empty capture reports min as 0 rather than the marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_frames_q <= '0;
      sh_runt_q   <= '0;
      sh_over_q   <= '0;
      sh_bytes_q  <= '0;
      sh_min_q    <= '0;
      sh_max_q    <= '0;
      sh_valid_q  <= 1'b0;
    end else begin
      sh_valid_q <= snapshot;
      if (snapshot) begin
        sh_frames_q <= upd_frames;
        sh_runt_q   <= upd_runt;
        sh_over_q   <= upd_over;
        sh_bytes_q  <= upd_bytes;
        sh_min_q    <= (upd_frames == '0) ? '0 : upd_min;
        sh_max_q    <= upd_max;
      end
    end
  end

  assign stat_frames   = sh_frames_q;
  assign stat_bytes    = sh_bytes_q;
  assign stat_min_len  = sh_min_q;
  assign stat_max_len  = sh_max_q;
  assign stat_runt     = sh_runt_q;
  assign stat_oversize = sh_over_q;
  assign stat_valid    = sh_valid_q;

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Bench for axis_frame_len_stats: directed cases with literal expectations,
// then random traffic, all checked every cycle against an unbounded-count model.
module tb_axis_frame_len_stats;
  localparam int LW = 16, CW = 4, BW = 20, MINL = 64, MAXL = 1518;
  localparam longint CMAX = (64'd1 << CW) - 1;
  localparam longint BMAX = (64'd1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] frame_len;
  logic          frame_len_valid, snapshot, clear_on_snap;
  logic [CW-1:0] stat_frames, stat_runt, stat_oversize;
  logic [BW-1:0] stat_bytes;
  logic [LW-1:0] stat_min_len, stat_max_len;
  logic          stat_valid;

  axis_frame_len_stats #(.LEN_WIDTH(LW), .COUNT_WIDTH(CW), .BYTE_WIDTH(BW),
                         .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .frame_len(frame_len), .frame_len_valid(frame_len_valid),
    .snapshot(snapshot), .clear_on_snap(clear_on_snap),
    .stat_frames(stat_frames), .stat_bytes(stat_bytes), .stat_min_len(stat_min_len),
    .stat_max_len(stat_max_len), .stat_runt(stat_runt), .stat_oversize(stat_oversize),
    .stat_valid(stat_valid));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: live totals kept unbounded, clamped only when copied to the shadow.
  longint m_frames = 0, m_bytes = 0, m_runt = 0, m_over = 0;
  int     m_min = 1 << 30, m_max = 0;
  longint e_frames = 0, e_bytes = 0, e_runt = 0, e_over = 0, e_min = 0, e_max = 0;
  logic   e_valid = 1'b0;

  function automatic longint clamp(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference model update on each clock edge or asynchronous reset.
  always @(posedge clk or posedge rst) begin : model
    longint nf, nb, nr, no;
    int nmin, nmax;
    if (rst) begin
      m_frames <= 0; m_bytes <= 0; m_runt <= 0; m_over <= 0;
      m_min <= 1 << 30; m_max <= 0;
      e_frames <= 0; e_bytes <= 0; e_runt <= 0; e_over <= 0;
      e_min <= 0; e_max <= 0; e_valid <= 1'b0;
    end else begin
      nf = m_frames; nb = m_bytes; nr = m_runt; no = m_over; nmin = m_min; nmax = m_max;
      if (frame_len_valid) begin
        nf = nf + 1;
        nb = nb + longint'(frame_len);
        if (int'(frame_len) < nmin) nmin = int'(frame_len);
        if (int'(frame_len) > nmax) nmax = int'(frame_len);
        if (int'(frame_len) < MINL) nr = nr + 1;
        if (int'(frame_len) > MAXL) no = no + 1;
      end
      e_valid <= snapshot;
      if (snapshot) begin
        e_frames <= clamp(nf, CMAX);
        e_bytes  <= clamp(nb, BMAX);
        e_runt   <= clamp(nr, CMAX);
        e_over   <= clamp(no, CMAX);
        e_min    <= (nf == 0) ? 0 : longint'(nmin);
        e_max    <= longint'(nmax);
      end
      if (snapshot && clear_on_snap) begin
        m_frames <= 0; m_bytes <= 0; m_runt <= 0; m_over <= 0;
        m_min <= 1 << 30; m_max <= 0;
      end else begin
        m_frames <= nf; m_bytes <= nb; m_runt <= nr; m_over <= no;
        m_min <= nmin; m_max <= nmax;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("frames", stat_frames, e_frames);
    chk("bytes", stat_bytes, e_bytes);
    chk("min_len", stat_min_len, e_min);
    chk("max_len", stat_max_len, e_max);
    chk("runt", stat_runt, e_runt);
    chk("oversize", stat_oversize, e_over);
    chk("stat_valid", stat_valid, e_valid);
  end

  task automatic frame(input int len);
    frame_len_valid = 1'b1; frame_len = LW'(len);
    @(posedge clk); #1;
    frame_len_valid = 1'b0;
  endtask

  // Snapshot (optionally with a coincident frame) and check literal results.
  task automatic snap(input bit clr, input bit fv, input int flen, input string tag,
                      input longint xf, input longint xb, input longint xmin,
                      input longint xmax, input longint xr, input longint xo);
    snapshot = 1'b1; clear_on_snap = clr;
    frame_len_valid = fv; frame_len = LW'(flen);
    @(posedge clk); #1;
    snapshot = 1'b0; clear_on_snap = 1'b0; frame_len_valid = 1'b0;
    chk({tag, " valid"}, stat_valid, 1);
    chk({tag, " frames"}, stat_frames, xf);
    chk({tag, " bytes"}, stat_bytes, xb);
    chk({tag, " min"}, stat_min_len, xmin);
    chk({tag, " max"}, stat_max_len, xmax);
    chk({tag, " runt"}, stat_runt, xr);
    chk({tag, " oversize"}, stat_oversize, xo);
    @(posedge clk); #1;
    chk({tag, " valid drop"}, stat_valid, 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " frames"}, stat_frames, 0);
    chk({tag, " bytes"}, stat_bytes, 0);
    chk({tag, " min"}, stat_min_len, 0);
    chk({tag, " max"}, stat_max_len, 0);
    chk({tag, " runt"}, stat_runt, 0);
    chk({tag, " oversize"}, stat_oversize, 0);
    chk({tag, " valid"}, stat_valid, 0);
  endtask

  initial begin
    rst = 1'b1; frame_len = '0; frame_len_valid = 1'b0;
    snapshot = 1'b0; clear_on_snap = 1'b0;
    repeat (2) @(posedge clk);
    #1 all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic accumulation
    frame(64); frame(100); frame(1518);
    snap(1, 0, 0, "t1", 3, 1682, 64, 1518, 0, 0);
    // 2: runt / oversize / zero length
    frame(0); frame(63); frame(1519);
    snap(1, 0, 0, "t2", 3, 1582, 0, 1519, 2, 1);
    // 3: coincident frame with clearing snapshot
    snap(1, 1, 200, "t3a", 1, 200, 200, 200, 0, 0);
    frame(300);
    snap(1, 0, 0, "t3b", 1, 300, 300, 300, 0, 0);
    // 4: empty snapshot after reset
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    snap(0, 0, 0, "t4", 0, 0, 0, 0, 0, 0);
    // 5: counter saturation
    repeat (20) frame(10);
    snap(0, 0, 0, "t5", 15, 200, 10, 10, 15, 0);
    // 6: asynchronous reset mid-stream between edges
    frame(100); frame(100);
    frame_len_valid = 1'b1; frame_len = 16'd700;
    #3 rst = 1'b1;
    #1 all_zero("t6 async");
    frame_len_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    frame(500);
    snap(0, 0, 0, "t6", 1, 500, 500, 500, 0, 0);

    // random traffic: frequent snapshots, then rare clears with big frames
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        frame_len_valid = ($urandom_range(0, 9) < (ph == 0 ? 5 : 8));
        case ($urandom_range(0, 3))
          0: frame_len = LW'($urandom_range(0, MINL - 1));
          1: frame_len = LW'($urandom_range(MINL, MAXL));
          2: frame_len = LW'($urandom_range(MAXL + 1, 2000));
          default: frame_len = LW'($urandom_range(0, 65535));
        endcase
        snapshot = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        clear_on_snap = (ph == 0) ? $urandom_range(0, 1) : ($urandom_range(0, 15) == 0);
        @(posedge clk); #1;
      end
    end
    frame_len_valid = 1'b0; snapshot = 1'b0; clear_on_snap = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
